fft_64p_frame_scheduler: RTL

- Frame-level scheduler that shares one fft_64p_16b_top core among NUM_CH sample sources.
- Grants a whole 64-sample frame to one requesting channel (round-robin), drives the core's stream-in handshake, and latches that frame's mode.
- Returns each output frame tagged with its originating channel via an in-order tag FIFO.
- Sits between the channel buffers and the core.

---
 rtl/fft_64p_pkg.sv | 39 +++
 rtl/fft_sched_tag_fifo.sv | 53 +++++
 rtl/fft_64p_frame_scheduler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fft_64p_pkg.sv
// Shared constants, FSM state type and round-robin helper for the 64-point FFT
// frame scheduler.
package fft_64p_pkg;

  localparam int unsigned FFT_FRAME_LEN = 64;
  localparam int unsigned FFT_SAMPLE_W  = 32;
  localparam int unsigned RR_MAX_CH     = 8;
  localparam int unsigned RR_IDX_W      = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } sched_state_t;

  // First requester after 'last', wrapping modulo num_ch; returns 'last' if none.
  function automatic logic [RR_IDX_W-1:0] rr_next(
    input logic [RR_MAX_CH-1:0] req,
    input logic [RR_IDX_W-1:0]  last,
    input int unsigned          num_ch
  );
    logic [RR_IDX_W-1:0] win;
    logic                found;
    int unsigned         idx;
    win   = last;
    found = 1'b0;
    for (int unsigned off = 1; off <= RR_MAX_CH; off++) begin
      if (!found && off <= num_ch) begin
        idx = (32'(last) + off) % num_ch;
        if (req[RR_IDX_W'(idx)]) begin
          win   = RR_IDX_W'(idx);
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/fft_sched_tag_fifo.sv
// In-order channel-tag FIFO: one entry per granted frame, popped at each
// output frame's last sample.
module fft_sched_tag_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];
  // A pop in the same cycle frees the slot a full push would need.
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/fft_64p_frame_scheduler.sv
// Shares one 64-point FFT core among NUM_CH sources: round-robin frame grants
// on the input side, channel-tagged output frames on the output side.
module fft_64p_frame_scheduler
  import fft_64p_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned FRAME_LEN = FFT_FRAME_LEN,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                ch_req,
  input  logic [NUM_CH-1:0]                ch_mode,
  input  logic [FFT_SAMPLE_W*NUM_CH-1:0]   ch_data,
  output logic [NUM_CH-1:0]                ch_rd,
  input  logic                             core_next_data,
  output logic [FFT_SAMPLE_W-1:0]          core_in_stream,
  output logic                             core_mode,
  output logic                             core_data_start,
  input  logic [FFT_SAMPLE_W-1:0]          core_out_stream,
  input  logic                             core_data_out,
  output logic [FFT_SAMPLE_W-1:0]          out_data,
  output logic                             out_valid,
  output logic [$clog2(NUM_CH)-1:0]        out_ch,
  output logic                             out_last,
  output logic                             busy,
  output logic                             err_orphan
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(FRAME_LEN);
  localparam int unsigned SW    = FFT_SAMPLE_W;

  sched_state_t       r_state;
  sched_state_t       w_state_nxt;
  logic [CNT_W-1:0]   r_in_cnt;
  logic [CNT_W-1:0]   r_out_cnt;
  logic [CH_W-1:0]    r_gnt_ch;
  logic [CH_W-1:0]    r_rr_last;
  logic               r_core_mode;
  logic               r_nd_low;
  logic               r_err_orphan;
  logic               w_nd_low_nxt;
  logic               w_grant;
  logic [CH_W-1:0]    w_gnt_win;
  logic [CH_W-1:0]    w_tag_head;
  logic               w_tag_full;
  logic               w_tag_empty;
  logic               w_tag_pop;
  logic [SW-1:0]      w_ch_sample [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_split
    assign w_ch_sample[g] = ch_data[SW*g +: SW];
  end

  assign w_gnt_win = CH_W'(rr_next(RR_MAX_CH'(ch_req), RR_IDX_W'(r_rr_last), NUM_CH));

  // Next state, grant decision and stream-side outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_nd_low_nxt    = r_nd_low;
    w_grant         = 1'b0;
    ch_rd           = '0;
    core_in_stream  = '0;
    core_data_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (core_next_data && (|ch_req) && !w_tag_full) begin
          w_grant      = 1'b1;
          w_nd_low_nxt = 1'b0;
          w_state_nxt  = STREAM;
        end
      end
      STREAM: begin
        ch_rd           = NUM_CH'(1) << r_gnt_ch;
        core_in_stream  = w_ch_sample[r_gnt_ch];
        core_data_start = (r_in_cnt == '0);
        if (!core_next_data) w_nd_low_nxt = 1'b1;
        if (r_in_cnt == CNT_W'(FRAME_LEN-1)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // Wait for the core to drop ready so a stale ready cannot re-grant.
        if (!core_next_data) w_nd_low_nxt = 1'b1;
        if (r_nd_low || !core_next_data) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_cnt    <= '0;
      r_gnt_ch    <= '0;
      r_core_mode <= 1'b0;
      r_rr_last   <= CH_W'(NUM_CH-1);
      r_nd_low    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_nd_low <= w_nd_low_nxt;
      if (r_state == STREAM) r_in_cnt <= r_in_cnt + CNT_W'(1);
      if (w_grant) begin
        r_gnt_ch    <= w_gnt_win;
        r_core_mode <= ch_mode[w_gnt_win];
        r_rr_last   <= w_gnt_win;
        r_in_cnt    <= '0;
      end
    end
  end

  // Output side: pass-through with frame counting and tag retirement.
  assign out_data  = core_out_stream;
  assign out_valid = core_data_out;
  assign out_last  = core_data_out && (r_out_cnt == CNT_W'(FRAME_LEN-1));
  assign w_tag_pop = out_last && !w_tag_empty;
  assign out_ch    = w_tag_empty ? '0 : w_tag_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_cnt    <= '0;
      r_err_orphan <= 1'b0;
    end else if (core_data_out) begin
      r_out_cnt <= r_out_cnt + CNT_W'(1);
      if (w_tag_empty) r_err_orphan <= 1'b1;
    end
  end

  fft_sched_tag_fifo #(
    .WIDTH (CH_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_grant),
    .i_din   (w_gnt_win),
    .i_pop   (w_tag_pop),
    .o_dout  (w_tag_head),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  assign core_mode  = r_core_mode;
  assign busy       = (r_state != IDLE) || !w_tag_empty;
  assign err_orphan = r_err_orphan;

endmodule
